hvac_zone_ctrl: RTL and testbench

Multi-zone, parametrised successor to the single-zone air-conditioning controller. Runs one independent heat/idle/cool hysteresis state machine per zone, with programmable thresholds and anti-short-cycle minimum dwell times. Sits between the per-zone temperature sensor registers and the heater/cooler drive outputs.

---
 rtl/hvac_zone_ctrl.sv | 139 +++++++++++++
 tb/tb_hvac_zone_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hvac_zone_ctrl.sv
// Multi-zone heat/idle/cool hysteresis controller with per-zone anti-short-cycle dwell timing.
// Optional sensor-fault detection is enabled by defining HVAC_ZONE_FAULT_EN.
module hvac_zone_ctrl #(
    parameter int ZONES    = 4,
    parameter int TW       = 5,
    parameter int HEAT_ON  = 18,
    parameter int HEAT_OFF = 20,
    parameter int COOL_ON  = 22,
    parameter int COOL_OFF = 20,
    parameter int MIN_ON   = 8,
    parameter int MIN_OFF  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ZONES-1:0]      zone_en,
    input  logic [ZONES*TW-1:0]   temperature,
    output logic [ZONES-1:0]      heating,
    output logic [ZONES-1:0]      cooling,
    output logic [ZONES-1:0]      fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    localparam int MAXD = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int DW   = $clog2(MAXD + 1);

    localparam logic [DW-1:0] MAXD_C     = DW'(MAXD);
    localparam logic [DW-1:0] MIN_ON_C   = DW'(MIN_ON);
    localparam logic [DW-1:0] MIN_OFF_C  = DW'(MIN_OFF);
    localparam logic [TW-1:0] HEAT_ON_C  = TW'(HEAT_ON);
    localparam logic [TW-1:0] HEAT_OFF_C = TW'(HEAT_OFF);
    localparam logic [TW-1:0] COOL_ON_C  = TW'(COOL_ON);
    localparam logic [TW-1:0] COOL_OFF_C = TW'(COOL_OFF);

    state_e          state_q [ZONES];
    state_e          state_d [ZONES];
    logic [DW-1:0]   dwell_q [ZONES];
    logic [DW-1:0]   dwell_d [ZONES];
    logic [TW-1:0]   temp_s  [ZONES];
    logic [ZONES-1:0] bad_s;
    logic [ZONES-1:0] heating_q, heating_d;
    logic [ZONES-1:0] cooling_q, cooling_d;
    logic [ZONES-1:0] fault_q, fault_d;

    for (genvar g = 0; g < ZONES; g++) begin : g_zone
        assign temp_s[g] = temperature[g*TW +: TW];
`ifdef HVAC_ZONE_FAULT_EN
        // A stuck-low or stuck-high reading is treated as a broken sensor.
        assign bad_s[g] = (temp_s[g] == {TW{1'b0}}) || (temp_s[g] == {TW{1'b1}});
`else
        assign bad_s[g] = 1'b0;
`endif
    end

    // Per-zone next-state, dwell counter and output decode.
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            state_d[i] = state_q[i];
            fault_d[i] = fault_q[i];
            if (!zone_en[i]) begin
                state_d[i] = ST_IDLE;
                fault_d[i] = 1'b0;
            end else if (bad_s[i] || fault_q[i]) begin
                state_d[i] = ST_IDLE;
                fault_d[i] = 1'b1;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (dwell_q[i] >= MIN_OFF_C && temp_s[i] <= HEAT_ON_C) begin
                            state_d[i] = ST_HEAT;
                        end else if (dwell_q[i] >= MIN_OFF_C && temp_s[i] >= COOL_ON_C) begin
                            state_d[i] = ST_COOL;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_HEAT: begin
                        if (dwell_q[i] >= MIN_ON_C && temp_s[i] >= HEAT_OFF_C) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            state_d[i] = ST_HEAT;
                        end
                    end
                    ST_COOL: begin
                        if (dwell_q[i] >= MIN_ON_C && temp_s[i] <= COOL_OFF_C) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            state_d[i] = ST_COOL;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end

            if (state_d[i] != state_q[i]) begin
                dwell_d[i] = {DW{1'b0}};
            end else if (dwell_q[i] == MAXD_C) begin
                dwell_d[i] = dwell_q[i];
            end else begin
                dwell_d[i] = dwell_q[i] + DW'(1);
            end

            heating_d[i] = (state_d[i] == ST_HEAT);
            cooling_d[i] = (state_d[i] == ST_COOL);
        end
    end

    // State, dwell and output registers; reset presets dwell to saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= ST_IDLE;
                dwell_q[i] <= MAXD_C;
            end
            heating_q <= {ZONES{1'b0}};
            cooling_q <= {ZONES{1'b0}};
            fault_q   <= {ZONES{1'b0}};
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= state_d[i];
                dwell_q[i] <= dwell_d[i];
            end
            heating_q <= heating_d;
            cooling_q <= cooling_d;
            fault_q   <= fault_d;
        end
    end

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Directed table-driven bench for hvac_zone_ctrl (default parameters, 4 zones).
module tb_hvac_zone_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  zone_en;
    logic [19:0] temperature;
    logic [3:0]  heating;
    logic [3:0]  cooling;
    logic [3:0]  fault;

    int total_cnt;
    int pass_cnt;

    typedef struct {
        string      name;
        logic [3:0] en;
        logic [19:0] temp;
        int         cyc;
        logic [3:0] eh;
        logic [3:0] ec;
        logic [3:0] ef;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    hvac_zone_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .zone_en     (zone_en),
        .temperature (temperature),
        .heating     (heating),
        .cooling     (cooling),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pk(input int t0, input int t1, input int t2, input int t3);
        logic [4:0] a, b, c, d;
        a = 5'(t0); b = 5'(t1); c = 5'(t2); d = 5'(t3);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] en, input logic [19:0] t,
                                input int cyc, input logic [3:0] eh, input logic [3:0] ec,
                                input logic [3:0] ef);
        vec_t v;
        v.name = n; v.en = en; v.temp = t; v.cyc = cyc;
        v.eh = eh; v.ec = ec; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        zone_en     = v.en;
        temperature = v.temp;
        for (int k = 0; k < v.cyc; k++) begin
            @(posedge clk);
            #1;
            chk({v.name, " excl"}, heating & cooling, 4'b0000);
        end
        chk({v.name, " heating"}, heating, v.eh);
        chk({v.name, " cooling"}, cooling, v.ec);
        chk({v.name, " fault"},   fault,   v.ef);
    endtask

    initial begin
        total_cnt   = 0;
        pass_cnt    = 0;
        rst_n       = 1'b0;
        zone_en     = 4'b0000;
        temperature = pk(20, 20, 20, 20);

        // Zone 0 heat cycle, minimum on-time 9 cycles
        vecs_a.push_back(mk("z0_heat_on",   4'b1111, pk(18, 20, 20, 20), 1, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z0_hold19",    4'b1111, pk(19, 20, 20, 20), 1, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z0_20_early",  4'b1111, pk(20, 20, 20, 20), 1, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z0_min_on",    4'b1111, pk(20, 20, 20, 20), 6, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z0_heat_off",  4'b1111, pk(20, 20, 20, 20), 1, 4'b0000, 4'b0000, 4'b0000));
        // Zone 1 cool cycle then MIN_OFF wait
        vecs_a.push_back(mk("z1_cool_on",   4'b1111, pk(20, 22, 20, 20), 1, 4'b0000, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z1_hold21",    4'b1111, pk(20, 21, 20, 20), 8, 4'b0000, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z1_cool_off",  4'b1111, pk(20, 20, 20, 20), 1, 4'b0000, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z1_min_off",   4'b1111, pk(20, 25, 20, 20), 4, 4'b0000, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z1_recool",    4'b1111, pk(20, 25, 20, 20), 1, 4'b0000, 4'b0010, 4'b0000));
        // Zone 0 HEAT stepped 15 -> 25 must pass through IDLE
        vecs_a.push_back(mk("z0_heat15",    4'b1111, pk(15, 25, 20, 20), 1, 4'b0001, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z0_step25",    4'b1111, pk(25, 25, 20, 20), 8, 4'b0001, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z0_to_idle",   4'b1111, pk(25, 25, 20, 20), 1, 4'b0000, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z0_idle_gap",  4'b1111, pk(25, 25, 20, 20), 4, 4'b0000, 4'b0010, 4'b0000));
        vecs_a.push_back(mk("z0_to_cool",   4'b1111, pk(25, 25, 20, 20), 1, 4'b0000, 4'b0011, 4'b0000));
        // All zones disabled, then distinct temperatures
        vecs_a.push_back(mk("all_off",      4'b0000, pk(25, 25, 20, 20), 5, 4'b0000, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("mixed",        4'b1111, pk(15, 20, 25, 19), 1, 4'b0001, 4'b0100, 4'b0000));
        vecs_a.push_back(mk("z2_off",       4'b1011, pk(15, 20, 25, 19), 1, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z2_on_wait",   4'b1111, pk(15, 20, 25, 19), 4, 4'b0001, 4'b0000, 4'b0000));
        vecs_a.push_back(mk("z2_recool",    4'b1111, pk(15, 20, 25, 19), 1, 4'b0001, 4'b0100, 4'b0000));
        // zone_en[0] dropped at dwell 2 bypasses MIN_ON
        vecs_a.push_back(mk("z0_dis",       4'b1110, pk(15, 20, 25, 19), 5, 4'b0000, 4'b0100, 4'b0000));
        vecs_a.push_back(mk("z0_reheat",    4'b1111, pk(15, 20, 25, 19), 1, 4'b0001, 4'b0100, 4'b0000));
        vecs_a.push_back(mk("z0_dwell2",    4'b1111, pk(15, 20, 25, 19), 2, 4'b0001, 4'b0100, 4'b0000));
        vecs_a.push_back(mk("z0_en_drop",   4'b1110, pk(15, 20, 25, 19), 1, 4'b0000, 4'b0100, 4'b0000));

        // After mid-run reset: first edge may leave IDLE immediately
        vecs_b.push_back(mk("post_rst",     4'b1111, pk(15, 20, 25, 19), 1, 4'b0001, 4'b0100, 4'b0000));
`ifdef HVAC_ZONE_FAULT_EN
        vecs_b.push_back(mk("z3_t31",       4'b1111, pk(15, 20, 25, 31), 1, 4'b0001, 4'b0100, 4'b1000));
        vecs_b.push_back(mk("z3_sticky",    4'b1111, pk(15, 20, 25, 15), 1, 4'b0001, 4'b0100, 4'b1000));
`else
        vecs_b.push_back(mk("z3_t31",       4'b1111, pk(15, 20, 25, 31), 1, 4'b0001, 4'b1100, 4'b0000));
        vecs_b.push_back(mk("z3_t15_hold",  4'b1111, pk(15, 20, 25, 15), 1, 4'b0001, 4'b1100, 4'b0000));
`endif
        vecs_b.push_back(mk("z3_en_drop",   4'b0111, pk(15, 20, 25, 15), 1, 4'b0001, 4'b0100, 4'b0000));
        vecs_b.push_back(mk("z3_heat",      4'b1111, pk(15, 20, 25, 15), 5, 4'b1001, 4'b0100, 4'b0000));
`ifdef HVAC_ZONE_FAULT_EN
        vecs_b.push_back(mk("z1_t0",        4'b1111, pk(15, 0, 25, 15),  1, 4'b1001, 4'b0100, 4'b0010));
`else
        vecs_b.push_back(mk("z1_t0",        4'b1111, pk(15, 0, 25, 15),  1, 4'b1011, 4'b0100, 4'b0000));
`endif

        #1;
        chk("rst heating", heating, 4'b0000);
        chk("rst cooling", cooling, 4'b0000);
        chk("rst fault",   fault,   4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs_a[i]) run_vec(vecs_a[i]);

        // Asynchronous reset mid-COOL clears outputs before any clock edge
        zone_en = 4'b1111;
        chk("pre_arst cooling", cooling, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst cooling", cooling, 4'b0000);
        chk("arst heating", heating, 4'b0000);
        #1;
        rst_n = 1'b1;

        foreach (vecs_b[i]) run_vec(vecs_b[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
